// File: rtl/wb_timer_array.sv
// Wishbone classic slave with NUM_CH prescaled down-counting timers,
// one-shot or periodic reload, sticky events and a masked interrupt line.
module wb_timer_array #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned PS_WIDTH = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o,
    output logic        tick_o
);

    logic [PS_WIDTH-1:0] prescale;
    logic [PS_WIDTH-1:0] ps_cnt;
    logic [NUM_CH-1:0]   status;
    logic [NUM_CH-1:0]   enable;
    logic [NUM_CH-1:0]   en;
    logic [NUM_CH-1:0]   periodic;
    logic [NUM_CH-1:0]   evt;
    logic [NUM_CH-1:0]   wr_ctrl;
    logic [NUM_CH-1:0]   wr_reload;
    logic [NUM_CH-1:0]   wr_count;
    logic [NUM_CH-1:0]   clr;
    logic [WIDTH-1:0]    reload [NUM_CH];
    logic [WIDTH-1:0]    count  [NUM_CH];
    logic                req;
    logic                wr;
    logic                tick;
    logic [5:0]          word;
    logic [3:0]          ch_sel;
    logic [1:0]          ch_reg;
    logic [31:0]         rd_data;
    logic                unused;

    assign req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr     = req & wbs_we_i;
    assign word   = wbs_adr_i[7:2];
    assign ch_sel = wbs_adr_i[7:4];
    assign ch_reg = wbs_adr_i[3:2];
    assign tick   = (ps_cnt == prescale);
    assign tick_o = tick & ~wb_rst_i;
    assign irq_o  = |(status & enable);
    assign clr    = (wr && word == 6'd1) ? wbs_dat_i[NUM_CH-1:0] : '0;
    assign unused = ^{wbs_sel_i, wbs_adr_i[31:8], wbs_adr_i[1:0], wbs_dat_i};

    // Channel c lives at byte offset 0x10*(c+1); registers 0..2 within it.
    always_comb begin
        wr_ctrl   = '0;
        wr_reload = '0;
        wr_count  = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (wr && ch_sel == 4'(c + 1)) begin
                wr_ctrl[c]   = (ch_reg == 2'd0);
                wr_reload[c] = (ch_reg == 2'd1);
                wr_count[c]  = (ch_reg == 2'd2);
            end
        end
    end

    // A bus write to CTRL/COUNT swallows that channel's tick, event included.
    always_comb begin
        evt = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            evt[c] = tick && en[c] && (count[c] == '0) && !wr_ctrl[c] && !wr_count[c];
        end
    end

    always_comb begin
        rd_data = '0;
        case (word)
            6'd0:    rd_data[PS_WIDTH-1:0] = prescale;
            6'd1:    rd_data[NUM_CH-1:0]   = status;
            6'd2:    rd_data[NUM_CH-1:0]   = enable;
            default: ;
        endcase
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_sel == 4'(c + 1)) begin
                case (ch_reg)
                    2'd0:    rd_data[1:0]       = {periodic[c], en[c]};
                    2'd1:    rd_data[WIDTH-1:0] = reload[c];
                    2'd2:    rd_data[WIDTH-1:0] = count[c];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            prescale  <= '0;
            ps_cnt    <= '0;
            status    <= '0;
            enable    <= '0;
            en        <= '0;
            periodic  <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                reload[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rd_data : '0;

            if (wr && word == 6'd0) begin
                prescale <= wbs_dat_i[PS_WIDTH-1:0];
                ps_cnt   <= '0;
            end else if (tick) begin
                ps_cnt <= '0;
            end else begin
                ps_cnt <= ps_cnt + PS_WIDTH'(1);
            end

            if (wr && word == 6'd2) begin
                enable <= wbs_dat_i[NUM_CH-1:0];
            end

            // Hardware set wins over a same-cycle W1C.
            status <= (status & ~clr) | evt;

            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (wr_reload[c]) begin
                    reload[c] <= wbs_dat_i[WIDTH-1:0];
                end
                if (wr_ctrl[c]) begin
                    en[c]       <= wbs_dat_i[0];
                    periodic[c] <= wbs_dat_i[1];
                end
                if (wr_count[c]) begin
                    count[c] <= wbs_dat_i[WIDTH-1:0];
                end
                if (tick && en[c] && !wr_ctrl[c] && !wr_count[c]) begin
                    if (count[c] != '0) begin
                        count[c] <= count[c] - WIDTH'(1);
                    end else if (periodic[c]) begin
                        count[c] <= reload[c];
                    end else begin
                        en[c] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_timer_array.sv
// Bench for wb_timer_array: register vectors from a table, timed sequences for
// periods, one-shot, collisions and reset; bus reads are scored through a queue.
`timescale 1ns/1ps
module tb_wb_timer_array;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned WIDTH    = 24;
    localparam int unsigned PS_WIDTH = 16;

    typedef struct {
        logic        rd;
        logic [31:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  sel   = 4'hF;
    logic [31:0] adr   = '0;
    logic [31:0] dat_w = '0;
    logic        ack;
    logic [31:0] dat_r;
    logic        irq;
    logic        tick;

    int   asserts  = 0;
    int   failures = 0;
    int   cycles   = 0;
    logic prev_ack = 1'b0;
    sb_t  mon_e;
    sb_t  sb_q[$];
    vec_t vecs[18];

    wb_timer_array #(
        .NUM_CH  (NUM_CH),
        .WIDTH   (WIDTH),
        .PS_WIDTH(PS_WIDTH)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_w),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_r),
        .irq_o    (irq),
        .tick_o   (tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycles <= cycles + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Every ack retires one queued transfer; reads compare the returned data.
    always @(negedge clk) begin
        if (ack) begin
            check("ack_single_cycle", {31'b0, prev_ack}, 32'd0);
            check("ack_has_pending_transfer", {31'b0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                if (mon_e.rd) check(mon_e.name, dat_r, mon_e.exp);
            end
        end else if (prev_ack) begin
            check("dat_zero_after_ack", dat_r, 32'd0);
        end
        prev_ack = ack;
    end

    task automatic bus_now(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] e, input string name);
        int unsigned n = 0;
        sb_q.push_back('{!w, e, name});
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 8);
        check({name, "_ack_latency"}, n, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] e, input string name);
        @(negedge clk);
        while (ack) @(negedge clk);
        bus_now(w, a, d, e, name);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, a, d, 32'd0, $sformatf("wr_%02h", a[7:0]));
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string name);
        bus(1'b0, a, 32'd0, e, name);
    endtask

    task automatic wait_irq(input string name, output int t);
        int unsigned n = 0;
        @(negedge clk);
        while (!irq && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_seen"}, {31'b0, irq}, 32'd1);
        t = cycles;
    endtask

    task automatic wait_tick(input string name);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tick && !ack) && n < 50);
        check(name, {31'b0, tick && !ack}, 32'd1);
    endtask

    initial begin
        int t1;
        int t2;
        int n;

        vecs[0]  = '{1'b1, 32'h00, 32'h0001_2345, 32'h0};
        vecs[1]  = '{1'b0, 32'h00, 32'h0,         32'h0000_2345};
        vecs[2]  = '{1'b1, 32'h08, 32'hFFFF_FFFF, 32'h0};
        vecs[3]  = '{1'b0, 32'h08, 32'h0,         32'h0000_000F};
        vecs[4]  = '{1'b1, 32'h14, 32'hFFFF_FFFF, 32'h0};
        vecs[5]  = '{1'b0, 32'h14, 32'h0,         32'h00FF_FFFF};
        vecs[6]  = '{1'b1, 32'h10, 32'hFFFF_FFFE, 32'h0};
        vecs[7]  = '{1'b0, 32'h10, 32'h0,         32'h0000_0002};
        vecs[8]  = '{1'b1, 32'h28, 32'h00AB_CDEF, 32'h0};
        vecs[9]  = '{1'b0, 32'h28, 32'h0,         32'h00AB_CDEF};
        vecs[10] = '{1'b1, 32'h7C, 32'hFFFF_FFFF, 32'h0};
        vecs[11] = '{1'b0, 32'h7C, 32'h0,         32'h0};
        vecs[12] = '{1'b0, 32'h1C, 32'h0,         32'h0};
        vecs[13] = '{1'b1, 32'h58, 32'h0000_0123, 32'h0};
        vecs[14] = '{1'b0, 32'h58, 32'h0,         32'h0};
        vecs[15] = '{1'b0, 32'h04, 32'h0,         32'h0};
        vecs[16] = '{1'b1, 32'h08, 32'h0,         32'h0};
        vecs[17] = '{1'b1, 32'h00, 32'h0,         32'h0};

        // Power-on reset
        repeat (3) begin
            @(negedge clk);
            check("por_outputs", {29'b0, ack, irq, tick}, 32'd0);
            check("por_dat", dat_r, 32'd0);
        end
        rst = 1'b0;

        foreach (vecs[i]) bus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].exp, $sformatf("vec%0d", i));
        wr(32'h10, 32'h0);
        wr(32'h14, 32'h0);
        wr(32'h28, 32'h0);

        // Periodic channel 0: PRESCALE=3, RELOAD=4 -> 20-cycle period
        wr(32'h00, 32'd3);
        wr(32'h14, 32'd4);
        wr(32'h18, 32'd4);
        wr(32'h08, 32'h1);
        wr(32'h10, 32'd3);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (tick) n++;
        end
        check("tick_count_ps3", n, 32'd10);
        wr(32'h04, 32'hF);
        wait_irq("periodic_ev1", t1);
        rd(32'h04, 32'h1, "periodic_status");
        check("periodic_irq_held", {31'b0, irq}, 32'd1);
        wr(32'h04, 32'h1);
        check("periodic_irq_cleared", {31'b0, irq}, 32'd0);
        wait_irq("periodic_ev2", t2);
        check("periodic_period", t2 - t1, 32'd20);
        wr(32'h10, 32'h0);
        wr(32'h04, 32'hF);

        // One-shot channel 2: COUNT=7, PRESCALE=0 -> event after 8 ticks, then idle
        wr(32'h00, 32'd0);
        wr(32'h38, 32'd7);
        wr(32'h08, 32'h4);
        wr(32'h04, 32'hF);
        wr(32'h30, 32'd1);
        t1 = cycles;
        wait_irq("oneshot_ev", t2);
        check("oneshot_latency", t2 - t1, 32'd8);
        rd(32'h30, 32'h0, "oneshot_ctrl");
        rd(32'h38, 32'h0, "oneshot_count");
        rd(32'h04, 32'h4, "oneshot_status");
        wr(32'h04, 32'h4);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (irq) n++;
        end
        check("oneshot_no_refire", n, 32'd0);
        rd(32'h04, 32'h0, "oneshot_status_quiet");

        // Independent channels, reloads 1..4, PRESCALE=3 -> periods 8/12/16/20
        wr(32'h00, 32'd3);
        for (int c = 0; c < 4; c++) begin
            wr(32'h14 + 16 * c, c + 1);
            wr(32'h18 + 16 * c, c + 1);
            wr(32'h10 + 16 * c, 32'd3);
        end
        for (int c = 0; c < 4; c++) begin
            wr(32'h08, 1 << c);
            wr(32'h04, 32'hF);
            wait_irq($sformatf("indep_ch%0d_ev1", c), t1);
            wr(32'h04, 32'hF);
            check($sformatf("indep_ch%0d_irq_cleared", c), {31'b0, irq}, 32'd0);
            wait_irq($sformatf("indep_ch%0d_ev2", c), t2);
            check($sformatf("indep_ch%0d_period", c), t2 - t1, (c + 2) * 4);
        end
        wr(32'h08, 32'hF0);
        wr(32'h04, 32'hF);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (irq) n++;
        end
        check("masked_irq_quiet", n, 32'd0);
        rd(32'h04, 32'hF, "masked_status_all");
        rd(32'h08, 32'h0, "enable_upper_ignored");
        for (int c = 0; c < 4; c++) wr(32'h10 + 16 * c, 32'h0);
        wr(32'h04, 32'hF);

        // Back-to-back reads: ack every second cycle
        wr(32'h08, 32'h5);
        @(negedge clk);
        while (ack) @(negedge clk);
        for (int k = 0; k < 3; k++) sb_q.push_back('{1'b1, 32'h5, $sformatf("b2b_rd%0d", k)});
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h08;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("b2b_ack%0d", k), {31'b0, ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k == 4) begin
                cyc = 1'b0; stb = 1'b0;
            end
        end
        wr(32'h08, 32'h0);

        // Collision: COUNT write on the tick where COUNT==0 drops the event
        wr(32'h00, 32'd9);
        wr(32'h28, 32'd0);
        wr(32'h20, 32'd3);
        wr(32'h24, 32'd5);
        wr(32'h04, 32'hF);
        wait_tick("coll_count_tick");
        bus_now(1'b1, 32'h28, 32'd9, 32'd0, "coll_count_wr");
        rd(32'h28, 32'd9, "coll_count_val");
        rd(32'h04, 32'h0, "coll_no_event");

        // Collision: W1C landing with a new event leaves the bit set
        wr(32'h28, 32'd0);
        wait_tick("coll_w1c_tick");
        bus_now(1'b1, 32'h04, 32'h2, 32'd0, "coll_w1c_wr");
        rd(32'h04, 32'h2, "coll_w1c_set_wins");
        rd(32'h28, 32'd5, "coll_reload");

        // Reset mid-count and mid-transfer
        wr(32'h08, 32'h2);
        check("pre_reset_irq", {31'b0, irq}, 32'd1);
        @(negedge clk);
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h04;
        repeat (3) begin
            @(negedge clk);
            check("rst_outputs", {29'b0, ack, irq, tick}, 32'd0);
            check("rst_dat", dat_r, 32'd0);
        end
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("post_rst_outputs", {30'b0, ack, irq}, 32'd0);
        rd(32'h00, 32'h0, "post_rst_prescale");
        rd(32'h04, 32'h0, "post_rst_status");
        rd(32'h08, 32'h0, "post_rst_enable");
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 3; r++) begin
                rd(32'h10 + 16 * c + 4 * r, 32'h0, $sformatf("post_rst_ch%0d_r%0d", c, r));
            end
        end
        check("post_rst_irq", {31'b0, irq}, 32'd0);

        n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no $finish by 1 ms, required completion");
        $fatal(1);
    end

endmodule

// File: doc/wb_timer_array.md
Name: wb_timer_array

Overview:
- Parametrised multi-channel down-counting timer peripheral.
- Wishbone classic slave on the user-project bus, for the rvj1 core in the Caravel user area.
- Generalises the single free-running timer to NUM_CH independent channels of WIDTH bits, with:
  - a shared prescaler;
  - one-shot or periodic reload;
  - sticky per-channel events and a masked, combined interrupt line.

Parameters:
- NUM_CH, 4: number of timer channels (1..15).
- WIDTH, 24: counter and reload width in bits (1..32).
- PS_WIDTH, 16: prescaler width in bits (1..32).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects (ignored; full-word access only)
- wbs_adr_i  in  32  byte address (bits [7:2] decoded)
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  transfer acknowledge
- wbs_dat_o  out  32  read data
- irq_o  out  1  |(IRQ_STATUS & IRQ_ENABLE)
- tick_o  out  1  prescaler tick pulse, for debug/LA

Behaviour:
- Reset (wb_rst_i=1 at a wb_clk_i edge) clears all of the following:
  - every register and counter;
  - wbs_ack_o=0, wbs_dat_o=0, irq_o=0, tick_o=0.
  - Reset asserted mid-count or mid-transfer aborts immediately; no event is raised.
- Register map (byte offsets). Unused bits read 0. Fields are zero-extended; bits above the field width are ignored on write.
  - 0x00 PRESCALE [PS_WIDTH-1:0] RW.
  - 0x04 IRQ_STATUS [NUM_CH-1:0] RW1C.
  - 0x08 IRQ_ENABLE [NUM_CH-1:0] RW.
  - 0x10*(c+1)+0x0 CTRL c: bit0 EN, bit1 PERIODIC; RW.
  - 0x10*(c+1)+0x4 RELOAD c [WIDTH-1:0] RW.
  - 0x10*(c+1)+0x8 COUNT c [WIDTH-1:0] RW; a write loads the counter directly.
  - Other offsets and channels >= NUM_CH: read 0, writes ignored, still acked.
- Wishbone handshake:
  - wbs_ack_o asserts the cycle after cyc&stb&!ack is sampled, and stays high for exactly 1 cycle.
  - Write takes effect at the same edge that raises ack.
  - wbs_dat_o is registered, valid while ack=1, and 0 otherwise.
  - Back-to-back strobes therefore complete every 2 cycles. No wait states, no errors.
- Prescaler:
  - ps_cnt increments every cycle.
  - When ps_cnt==PRESCALE: ps_cnt<=0 and tick_o=1 for that cycle.
  - Tick period is PRESCALE+1 cycles; PRESCALE=0 gives a tick every cycle.
  - Writing PRESCALE clears ps_cnt.
- Per-channel, on a tick with EN=1:
  - COUNT!=0: COUNT<=COUNT-1.
  - COUNT==0: set IRQ_STATUS[c]. Then PERIODIC=1 gives COUNT<=RELOAD; PERIODIC=0 gives EN<=0 and COUNT stays 0.
  - Period is therefore (RELOAD+1)*(PRESCALE+1) cycles.
  - EN=0 freezes COUNT. Non-tick cycles leave COUNT unchanged.
- Simultaneous events:
  - A bus write to COUNT/CTRL in the same cycle as a tick: the bus write wins and that tick's decrement/event for the channel is dropped.
  - A W1C clear and a hardware set of the same status bit in the same cycle: set wins.
- irq_o is combinational from the registered status/enable. It is level-type and stays high until software clears it.
- Status bits set regardless of IRQ_ENABLE.
- All arithmetic is WIDTH-bit unsigned. Decrement never wraps, because the zero case reloads or stops instead.

Test Plan:
- Reset: hold wb_rst_i 3 cycles mid-count → all reads 0, irq_o=0, wbs_ack_o=0 next cycle.
- Periodic: PRESCALE=3, RELOAD ch0=4, COUNT=4, CTRL=3, IRQ_ENABLE=1 → IRQ_STATUS[0] sets every 20 cycles. irq_o high until 0x04 is written with 1. Then re-fires 20 cycles after the previous event.
- One-shot: ch2 PRESCALE=0, COUNT=7, CTRL=1 → status[2] set after 8 ticks. CTRL reads 0, COUNT reads 0, no further events over 100 cycles.
- Channel independence: NUM_CH=4, reloads 1/2/3/4 periodic, PRESCALE=0 → event periods 2/3/4/5 cycles. Only enabled bits drive irq_o.
- Collisions:
  - Write COUNT=9 on the tick where COUNT==0 → no event that tick, COUNT reads 9.
  - W1C on the same cycle as a new event → bit remains 1.
- Bus: unmapped 0x7C read → ack after 1 cycle with data 0. Back-to-back reads show ack pulses every 2nd cycle. WIDTH=24 write 0xFFFFFFFF to RELOAD → reads 0x00FFFFFF.
